// File: rtl/mips_alu_pkg.sv
// ----------------------------------------------------------------------------
// mips_alu_pkg
// Shared definitions for the registered MIPS ALU with iterative multiply/divide.
//   - ALU control codes (CTL_W_DEF bits wide)
//   - FSM state encoding for the top-level handshake controller
// ----------------------------------------------------------------------------
package mips_alu_pkg;

    localparam int unsigned CTL_W_DEF = 4;

    localparam logic [CTL_W_DEF-1:0] ALU_AND   = 4'd0;
    localparam logic [CTL_W_DEF-1:0] ALU_OR    = 4'd1;
    localparam logic [CTL_W_DEF-1:0] ALU_ADD   = 4'd2;
    localparam logic [CTL_W_DEF-1:0] ALU_SLTU  = 4'd3;
    localparam logic [CTL_W_DEF-1:0] ALU_SUB   = 4'd6;
    localparam logic [CTL_W_DEF-1:0] ALU_SLT   = 4'd7;
    localparam logic [CTL_W_DEF-1:0] ALU_MULTU = 4'd8;
    localparam logic [CTL_W_DEF-1:0] ALU_DIVU  = 4'd9;
    localparam logic [CTL_W_DEF-1:0] ALU_NOR   = 4'd12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mips_alu_mdu_if.sv
// ----------------------------------------------------------------------------
// mips_alu_mdu_if
// Request/response bundle between decode (master) and the ALU/MDU (slave).
//   in_valid/in_ready  : request handshake, alu_ctl/a/b are the request payload
//   out_valid/out_ready: response handshake, result_lo/result_hi/zero payload
//   ovf                : signed ADD/SUB overflow, present only with ALU_OVERFLOW_EN
// ----------------------------------------------------------------------------
interface mips_alu_mdu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
`ifdef ALU_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, alu_ctl, a, b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, zero, ovf
    );
    modport slave (
        input  in_valid, alu_ctl, a, b, out_ready,
        output in_ready, out_valid, result_lo, result_hi, zero, ovf
    );
`else
    modport master (
        output in_valid, alu_ctl, a, b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, zero
    );
    modport slave (
        input  in_valid, alu_ctl, a, b, out_ready,
        output in_ready, out_valid, result_lo, result_hi, zero
    );
`endif
endinterface

// File: rtl/mips_mdu_iter.sv
// ----------------------------------------------------------------------------
// mips_mdu_iter
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle for WIDTH cycles.
//   clk, rst     : clock, synchronous active-high reset
//   i_start      : load operands and begin (i_div selects divide)
//   i_a, i_b     : multiplicand/dividend, multiplier/divisor
//   o_done       : high during the final iteration cycle
//   o_hi, o_lo   : value of {hi,lo} after the current iteration; valid with o_done
//                  (product {hi,lo}; or remainder hi, quotient lo)
// ----------------------------------------------------------------------------
module mips_mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        w_sum    = '0;
        w_shift  = '0;
        if (r_div) begin
            // hi is the partial remainder, lo shifts the dividend out and the
            // quotient in. A zero divisor always "fits", giving all-ones/a.
            w_shift = {r_hi, r_lo[WIDTH-1]};
            if (w_shift >= {1'b0, r_b}) begin
                w_sum    = w_shift - {1'b0, r_b};
                w_hi_nxt = w_sum[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // hi accumulates, lo holds the multiplier and fills with product bits.
            w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
            {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[WIDTH-1:1]};
        end
    end

    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_div  <= i_div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= i_a;
            r_b    <= i_b;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_alu_mdu.sv
// ----------------------------------------------------------------------------
// mips_alu_mdu
// Registered MIPS ALU with valid/ready handshakes and an iterative MULTU/DIVU.
// One operation in flight; in_ready only in IDLE, result held in DONE until
// out_ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mips_alu_mdu_if.slave (request a/b/alu_ctl, response lo/hi/zero)
// Optional feature macro ALU_OVERFLOW_EN adds bus.ovf (signed ADD/SUB overflow).
// ----------------------------------------------------------------------------
module mips_alu_mdu
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTL_W = CTL_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mips_alu_mdu_if.slave  bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;

    logic             w_accept;
    logic             w_is_mdu;
    logic             w_is_div;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_mdu_done;
    logic [WIDTH-1:0] w_mdu_hi;
    logic [WIDTH-1:0] w_mdu_lo;

    assign w_is_div = (bus.alu_ctl == CTL_W'(ALU_DIVU));
    assign w_is_mdu = (bus.alu_ctl == CTL_W'(ALU_MULTU)) || w_is_div;
    assign w_accept = bus.in_valid && (r_state == StIdle);
    assign w_sum    = bus.a + bus.b;
    assign w_diff   = bus.a - bus.b;

    // Single-cycle datapath; MULTU/DIVU and undefined codes yield 0 here.
    always_comb begin
        w_alu_res = '0;
        case (bus.alu_ctl)
            CTL_W'(ALU_AND):  w_alu_res = bus.a & bus.b;
            CTL_W'(ALU_OR):   w_alu_res = bus.a | bus.b;
            CTL_W'(ALU_ADD):  w_alu_res = w_sum;
            CTL_W'(ALU_SUB):  w_alu_res = w_diff;
            CTL_W'(ALU_SLT):  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            CTL_W'(ALU_SLTU): w_alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            CTL_W'(ALU_NOR):  w_alu_res = ~(bus.a | bus.b);
            default:          w_alu_res = '0;
        endcase
    end

    mips_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && w_is_mdu),
        .i_div   (w_is_div),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_done  (w_mdu_done),
        .o_hi    (w_mdu_hi),
        .o_lo    (w_mdu_lo)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (bus.in_valid) w_state_nxt = w_is_mdu ? StBusy : StDone;
            StBusy:  if (w_mdu_done) w_state_nxt = StDone;
            StDone:  if (bus.out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_zero <= 1'b1;
        end else if (w_accept && !w_is_mdu) begin
            r_lo   <= w_alu_res;
            r_hi   <= '0;
            r_zero <= (w_alu_res == '0);
        end else if (w_mdu_done) begin
            r_lo   <= w_mdu_lo;
            r_hi   <= w_mdu_hi;
            r_zero <= (w_mdu_lo == '0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic w_alu_ovf;
    logic r_ovf;

    // Overflow: ADD with like-signed operands, or SUB with unlike-signed
    // operands, where the result sign differs from a.
    always_comb begin
        w_alu_ovf = 1'b0;
        if (bus.alu_ctl == CTL_W'(ALU_ADD)) begin
            w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
        end else if (bus.alu_ctl == CTL_W'(ALU_SUB)) begin
            w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_alu_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.result_lo = r_lo;
    assign bus.result_hi = r_hi;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// ----------------------------------------------------------------------------
// tb_mips_alu_mdu
// Scoreboard bench for mips_alu_mdu: the driver pushes expected responses from
// an arithmetic reference model, the monitor pops and compares on each output
// transfer and also checks in_ready, latency and hold-under-backpressure.
// Honours ALU_OVERFLOW_EN for the ovf output.
// ----------------------------------------------------------------------------
module tb_mips_alu_mdu;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_alu_mdu_if #(.WIDTH(W), .CTL_W(4)) bus ();

    mips_alu_mdu #(
        .WIDTH (W),
        .CTL_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   bp_hold = 0;
    bit   pending = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.lo  = '0;
        e.hi  = '0;
        e.ovf = 1'b0;
        e.lat = 1;
        case (ctl)
            4'd0:  e.lo = a & b;
            4'd1:  e.lo = a | b;
            4'd2: begin
                e.lo  = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.lo[W-1] != a[W-1]);
            end
            4'd6: begin
                e.lo  = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.lo[W-1] != a[W-1]);
            end
            4'd7:  e.lo = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd3:  e.lo = (a < b) ? 1 : 0;
            4'd12: e.lo = ~(a | b);
            4'd8: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.lo  = p[W-1:0];
                e.hi  = p[2*W-1:W];
                e.lat = W + 1;
            end
            4'd9: begin
                e.lo  = (b == 0) ? '1 : a / b;
                e.hi  = (b == 0) ? a : a % b;
                e.lat = W + 1;
            end
            default: e.lo = '0;
        endcase
        e.zero = (e.lo == '0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(posedge clk);
        #1;
        q.push_back(model(ctl, a, b));
        bus.in_valid = 1'b1;
        bus.alu_ctl  = ctl;
        bus.a        = a;
        bus.b        = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 300);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Consumer backpressure: forced low while bp_hold runs, else mostly ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold > 0) begin
                bus.out_ready = 1'b0;
                bp_hold--;
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: all sampling on the falling edge.
    logic         prev_ov   = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] hold_lo, hold_hi;
    logic         hold_zero;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_ov   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!pending));
            if (bus.out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    check("latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
                end
            end
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_lo", 64'(bus.result_lo), 64'(hold_lo));
                check("hold_hi", 64'(bus.result_hi), 64'(hold_hi));
                check("hold_zero", 64'(bus.zero), 64'(hold_zero));
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("result_lo", 64'(bus.result_lo), 64'(e.lo));
                check("result_hi", 64'(bus.result_hi), 64'(e.hi));
                check("zero", 64'(bus.zero), 64'(e.zero));
`ifdef ALU_OVERFLOW_EN
                check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
                pending = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                pending = 1'b1;
                acc_cyc = cyc;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_ov   = bus.out_valid;
            hold_lo   = bus.result_lo;
            hold_hi   = bus.result_hi;
            hold_zero = bus.zero;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_lo"}, 64'(bus.result_lo), 64'(0));
        check({tag, "_hi"}, 64'(bus.result_hi), 64'(0));
        check({tag, "_zero"}, 64'(bus.zero), 64'(1));
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(0));
`endif
    endtask

    initial begin
        logic [3:0]   codes [16];
        logic [W-1:0] edges [4];
        logic [W-1:0] ra, rb;
        int           n;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd12, 4'd8,
                  4'd9, 4'd4, 4'd5, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
        edges = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        bus.in_valid = 1'b0;
        bus.alu_ctl  = '0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        issue(4'd2, 32'd7, 32'd4);
        issue(4'd6, 32'd3, 32'd3);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        issue(4'd3, 32'hFFFF_FFFF, 32'd1);
        issue(4'd12, 32'd0, 32'd0);
        issue(4'd8, 32'hFFFF_FFFF, 32'd2);
        issue(4'd9, 32'd10, 32'd3);
        issue(4'd9, 32'd10, 32'd0);
        issue(4'd2, 32'h7FFF_FFFF, 32'd1);
        issue(4'd6, 32'h8000_0000, 32'd1);
        issue(4'd5, 32'd9, 32'd9);
        bp_hold = 7;
        issue(4'd2, 32'd5, 32'd6);

        // Reset in the middle of a MULTU discards it.
        issue(4'd8, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        pending = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        issue(4'd2, 32'd1, 32'd1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); end
                default: begin ra = edges[$urandom_range(0, 3)]; rb = edges[$urandom_range(0, 3)]; end
            endcase
            issue(codes[$urandom_range(0, 15)], ra, rb);
        end

        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending responses got %0d required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
